// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the execute-stage ALU.
// Forwards results from EX/MEM and MEM/WB, and inserts a one-cycle bubble on a load-use hazard.
module id_ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_src_data,
    input  logic [DATA_W-1:0] id_dst_data,
    input  logic [REG_AW-1:0] id_src_reg,
    input  logic [REG_AW-1:0] id_dst_reg,
    input  logic              id_src_used,
    input  logic              id_dst_used,
    input  logic              id_alu_add,
    input  logic              id_alu_not,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_wb_reg,
    input  logic              flush,
    input  logic              exm_valid,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_wb_reg,
    input  logic [DATA_W-1:0] exm_result,
    input  logic              mwb_valid,
    input  logic              mwb_reg_write,
    input  logic [REG_AW-1:0] mwb_wb_reg,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [DATA_W-1:0] Src,
    output logic [DATA_W-1:0] Dst,
    output logic              ALU_ADD,
    output logic              ALU_NOT,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic [REG_AW-1:0] ex_wb_reg
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] src_data;
        logic [DATA_W-1:0] dst_data;
        logic [REG_AW-1:0] src_reg;
        logic [REG_AW-1:0] dst_reg;
        logic              src_used;
        logic              dst_used;
        logic              alu_add;
        logic              alu_not;
        logic              reg_write;
        logic              mem_read;
        logic [REG_AW-1:0] wb_reg;
    } ex_t;

    ex_t ex_q, ex_d;

    // A load in EX whose destination is read by decode cannot be forwarded in time.
    always_comb begin
        stall_id = ex_q.valid & ex_q.mem_read & id_valid & ~flush &
                   ((id_src_used & (id_src_reg == ex_q.wb_reg)) |
                    (id_dst_used & (id_dst_reg == ex_q.wb_reg)));
    end

    always_comb begin
        ex_d.valid     = id_valid;
        ex_d.src_data  = id_src_data;
        ex_d.dst_data  = id_dst_data;
        ex_d.src_reg   = id_src_reg;
        ex_d.dst_reg   = id_dst_reg;
        ex_d.src_used  = id_src_used & id_valid;
        ex_d.dst_used  = id_dst_used & id_valid;
        ex_d.alu_add   = id_alu_add & id_valid;
        ex_d.alu_not   = id_alu_not & id_valid;
        ex_d.reg_write = id_reg_write & id_valid;
        ex_d.mem_read  = id_mem_read & id_valid;
        ex_d.wb_reg    = id_wb_reg;
        // Flush and load-use stall both turn the slot into an empty bubble.
        if (flush || stall_id) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    function automatic logic [DATA_W-1:0] fwd(input logic              used,
                                               input logic [REG_AW-1:0] r,
                                               input logic [DATA_W-1:0] rf);
        logic [DATA_W-1:0] v;
        v = rf;
        if (used) begin
            if (exm_valid && exm_reg_write && (exm_wb_reg == r)) begin
                v = exm_result;
            end else if (mwb_valid && mwb_reg_write && (mwb_wb_reg == r)) begin
                v = mwb_result;
            end
        end
        return v;
    endfunction

    always_comb begin
        Src          = fwd(ex_q.src_used, ex_q.src_reg, ex_q.src_data);
        Dst          = fwd(ex_q.dst_used, ex_q.dst_reg, ex_q.dst_data);
        ex_valid     = ex_q.valid;
        ALU_ADD      = ex_q.valid & ex_q.alu_add;
        ALU_NOT      = ex_q.valid & ex_q.alu_not;
        ex_reg_write = ex_q.valid & ex_q.reg_write;
        ex_mem_read  = ex_q.valid & ex_q.mem_read;
        ex_wb_reg    = ex_q.wb_reg;
    end

endmodule
